// File: rtl/vec_dot_arbiter_pkg.sv
// vec_dot_pkg: shared types and constants for the vec_dot arbiter slice.
// Revision 1.0
`default_nettype none
package vec_dot_pkg;
  localparam int VEC_DOT_LATENCY = 33;
  localparam int VEC_SIZE        = 32;
  localparam int NREQ_DEFAULT    = 4;

  typedef logic [2:0][VEC_SIZE-1:0]         vec3_t;
  typedef logic [$clog2(NREQ_DEFAULT)-1:0] tag_t;

  // Round-robin successor of index g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/vec_dot_arbiter_tag.sv
// tag_fifo: synchronous first-word-fall-through FIFO of requester tags.
// Revision 1.0
`default_nettype none
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  // Depth need not be a power of two, so pointers wrap explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/vec_dot_arbiter.sv
// vec_dot_arbiter: round-robin share of one vec_dot unit, results routed back by tag.
// Optional counters via VEC_DOT_ARB_STATS_EN. Revision 1.0
`default_nettype none
module vec_dot_arbiter
  import vec_dot_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 40
) (
  input  logic                           aclk,
  input  logic                           rst,
  input  logic [NREQ-1:0][2:0][SIZE-1:0] s_axis_a_tdata,
  input  logic [NREQ-1:0][2:0][SIZE-1:0] s_axis_b_tdata,
  input  logic [NREQ-1:0]                s_axis_tvalid,
  output logic [NREQ-1:0]                s_axis_tready,
  output logic [SIZE-1:0]                m_axis_result_tdata,
  output logic [NREQ-1:0]                m_axis_result_tvalid,
  input  logic [NREQ-1:0]                m_axis_result_tready,
  output logic [2:0][SIZE-1:0]           dot_a_tdata,
  output logic [2:0][SIZE-1:0]           dot_b_tdata,
  output logic                           dot_tvalid,
  input  logic                           dot_tready,
  input  logic [SIZE-1:0]                dot_result_tdata,
  input  logic                           dot_result_tvalid,
  output logic                           dot_result_tready,
  output logic                           err_orphan
`ifdef VEC_DOT_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][31:0]          grant_cnt,
  output logic [31:0]                    stall_cnt
`endif
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [TW-1:0] r_rr_ptr;
  logic [CW-1:0] r_out_cnt;
  logic          r_err_orphan;
  logic [TW-1:0] w_grant;
  logic [TW-1:0] w_head;
  logic          w_any_valid;
  logic          w_issue_ok;
  logic          w_issue;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_retire;
  logic          w_orphan;

  // Descending scan so the valid requester closest to r_rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (s_axis_tvalid[idx]) begin
        w_grant     = TW'(idx);
        w_any_valid = 1'b1;
      end
    end
  end

  assign w_issue_ok = !rst && dot_tready && (r_out_cnt < CW'(MAX_OUT)) && !w_fifo_full;
  assign w_issue    = w_issue_ok && w_any_valid;

  always_comb begin
    s_axis_tready = '0;
    if (w_issue) s_axis_tready[w_grant] = 1'b1;
  end

  assign dot_tvalid  = w_issue;
  assign dot_a_tdata = s_axis_a_tdata[w_grant];
  assign dot_b_tdata = s_axis_b_tdata[w_grant];

  // Return side: a stalled owner stalls vec_dot; tagless results are always drained.
  assign m_axis_result_tdata = dot_result_tdata;
  assign dot_result_tready   = !rst && (w_fifo_empty ? 1'b1 : m_axis_result_tready[w_head]);
  assign w_retire = dot_result_tvalid && dot_result_tready && !w_fifo_empty;
  assign w_orphan = dot_result_tvalid && !rst && w_fifo_empty;

  always_comb begin
    m_axis_result_tvalid = '0;
    if (dot_result_tvalid && !w_fifo_empty && !rst) m_axis_result_tvalid[w_head] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_out_cnt    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_issue) r_rr_ptr <= TW'(rr_next(int'(w_grant), NREQ));
      case ({w_issue, w_retire})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
      if (w_orphan) r_err_orphan <= 1'b1;
    end
  end

  assign err_orphan = r_err_orphan;

  tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk     (aclk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_din   (w_grant),
    .i_pop   (w_retire),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef VEC_DOT_ARB_STATS_EN
  logic [NREQ-1:0][31:0] r_grant_cnt;
  logic [31:0]           r_stall_cnt;

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue) r_grant_cnt[w_grant] <= r_grant_cnt[w_grant] + 32'd1;
      if (w_any_valid && !w_issue_ok) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vec_dot_arbiter.sv
// tb_vec_dot_arbiter: randomized self-checking bench with a behavioural vec_dot and arbitration model.
`default_nettype none
module tb_vec_dot_arbiter;
  localparam int N   = 4;
  localparam int SZ  = 32;
  localparam int MO  = 40;
  localparam int LAT = 33;

  logic                      aclk = 1'b0;
  logic                      rst  = 1'b1;
  logic [N-1:0][2:0][SZ-1:0] a_d, b_d;
  logic [N-1:0]              s_valid, s_ready, m_valid, m_ready;
  logic [SZ-1:0]             m_data, dot_rdata;
  logic [2:0][SZ-1:0]        dot_a, dot_b;
  logic                      dot_tvalid, dot_tready, dot_rvalid, dot_rready, err_orphan;

  always #5 aclk = ~aclk;

  vec_dot_arbiter #(.SIZE(SZ), .NREQ(N), .MAX_OUT(MO)) dut (
    .aclk                 (aclk),
    .rst                  (rst),
    .s_axis_a_tdata       (a_d),
    .s_axis_b_tdata       (b_d),
    .s_axis_tvalid        (s_valid),
    .s_axis_tready        (s_ready),
    .m_axis_result_tdata  (m_data),
    .m_axis_result_tvalid (m_valid),
    .m_axis_result_tready (m_ready),
    .dot_a_tdata          (dot_a),
    .dot_b_tdata          (dot_b),
    .dot_tvalid           (dot_tvalid),
    .dot_tready           (dot_tready),
    .dot_result_tdata     (dot_rdata),
    .dot_result_tvalid    (dot_rvalid),
    .dot_result_tready    (dot_rready),
    .err_orphan           (err_orphan)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int outst  = 0;
  int n_left [N];
  bit hold, inj, auto_rand;

  typedef struct { logic [SZ-1:0] data; int due; } vd_t;
  typedef struct { logic [N-1:0] mask; logic dtr; int outst; logic [N-1:0] rdy; } cyc_t;
  typedef struct { int idx; logic [SZ-1:0] data; int cyc; } rec_t;
  vd_t  vd_q[$];
  cyc_t cyc_log[$];
  rec_t iss_log[$];
  rec_t res_log[$];

  logic [N-1:0] smp_ready, smp_mvalid;
  logic         smp_rready, smp_dtv;

  // Integer-valued floats only: enough to build exact reference dot products.
  function automatic logic [31:0] int2fp(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v >= (1 << i)) p = i;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(p + 127), m[22:0]};
  endfunction

  function automatic int fp2int(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] dot_ref(input logic [2:0][SZ-1:0] a, input logic [2:0][SZ-1:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) s += fp2int(a[k]) * fp2int(b[k]);
    return int2fp(s);
  endfunction

  task automatic new_req(input int i);
    for (int k = 0; k < 3; k++) begin
      a_d[i][k] = int2fp(int'($urandom_range(0, 15)));
      b_d[i][k] = int2fp(int'($urandom_range(0, 15)));
    end
    s_valid[i] = 1'b1;
  endtask

  task automatic drive_model();
    dot_rvalid = inj || (!hold && vd_q.size() > 0 && vd_q[0].due <= cyc);
    dot_rdata  = inj ? 32'hDEADBEEF : (vd_q.size() > 0 ? vd_q[0].data : 32'h0);
  endtask

  // One clock: sample just after the negedge drive, log handshakes, redrive at the next negedge.
  task automatic step();
    logic [N-1:0] acc;
    acc = '0;
    #1;
    smp_ready  = s_ready;
    smp_mvalid = m_valid;
    smp_rready = dot_rready;
    smp_dtv    = dot_tvalid;
    if (!rst) begin
      cyc_log.push_back('{s_valid, dot_tready, outst, s_ready});
      for (int i = 0; i < N; i++)
        if (s_valid[i] && s_ready[i]) begin
          acc[i] = 1'b1;
          iss_log.push_back('{i, dot_ref(a_d[i], b_d[i]), cyc});
        end
      if (dot_tvalid && dot_tready) begin
        vd_q.push_back('{dot_ref(dot_a, dot_b), cyc + LAT});
        outst++;
      end
      if (dot_rvalid && dot_rready && !inj && vd_q.size() > 0) begin
        void'(vd_q.pop_front());
        outst--;
      end
      for (int i = 0; i < N; i++)
        if (m_valid[i] && m_ready[i]) res_log.push_back('{i, m_data, cyc});
    end
    @(negedge aclk);
    cyc++;
    if (rst) begin
      vd_q.delete();
      outst = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        n_left[i]--;
        if (n_left[i] > 0) new_req(i);
        else s_valid[i] = 1'b0;
      end
      if (auto_rand && !s_valid[i] && $urandom_range(0, 3) == 0) begin
        n_left[i] = 1;
        new_req(i);
      end
    end
    drive_model();
  endtask

  task automatic clear_logs();
    cyc_log.delete();
    iss_log.delete();
    res_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = '0; hold = 0; inj = 0; auto_rand = 0;
    dot_tready = 1'b1; m_ready = '1;
    for (int i = 0; i < N; i++) n_left[i] = 0;
    repeat (3) step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1; dot_tready = 1'b1; m_ready = '1;
    for (int i = 0; i < N; i++) begin n_left[i] = 1; new_req(i); end
    drive_model();
    repeat (3) begin
      step();
      checks++;
      if (smp_ready !== '0 || smp_mvalid !== '0 || smp_dtv !== 1'b0 || err_orphan !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: tready=%b mvalid=%b dot_tvalid=%b err=%b, required all 0",
                 smp_ready, smp_mvalid, smp_dtv, err_orphan);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (smp_ready !== 4'b0001) begin
      errors++;
      $display("FAIL grant_after_reset: tready=%b required 0001", smp_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    int rdy_cycles, first_mv;
    bit seen_mv;
    rdy_cycles = 0; first_mv = 0; seen_mv = 0;
    a_d[0][0] = int2fp(1); a_d[0][1] = int2fp(2); a_d[0][2] = int2fp(3);
    b_d[0][0] = int2fp(4); b_d[0][1] = int2fp(5); b_d[0][2] = int2fp(6);
    s_valid[0] = 1'b1; n_left[0] = 1;
    for (int t = 0; t < 60 && res_log.size() == 0; t++) begin
      step();
      if (smp_ready[0]) rdy_cycles++;
      if (!seen_mv && smp_mvalid != '0) begin seen_mv = 1; first_mv = int'(smp_mvalid); end
    end
    checks++;
    if (res_log.size() != 1 || iss_log.size() != 1) begin
      errors++;
      $display("FAIL single_timeout: results=%0d issues=%0d required 1/1", res_log.size(), iss_log.size());
    end else begin
      checks++;
      if (res_log[0].cyc - iss_log[0].cyc != LAT) begin
        errors++;
        $display("FAIL single_latency: got %0d required %0d", res_log[0].cyc - iss_log[0].cyc, LAT);
      end
      checks++;
      if (res_log[0].data !== 32'h42000000) begin
        errors++;
        $display("FAIL single_data: got %h required 42000000", res_log[0].data);
      end
    end
    checks++;
    if (rdy_cycles != 1 || first_mv != 1) begin
      errors++;
      $display("FAIL single_handshake: tready cycles=%0d first mvalid=%0d required 1/1", rdy_cycles, first_mv);
    end
    do_reset();
  endtask

  task automatic test_fairness();
    int per [N];
    for (int i = 0; i < N; i++) begin per[i] = 0; n_left[i] = 4; new_req(i); end
    for (int t = 0; t < 200 && res_log.size() < 16; t++) step();
    checks++;
    if (iss_log.size() != 16 || res_log.size() != 16) begin
      errors++;
      $display("FAIL fair_count: issues=%0d results=%0d required 16/16", iss_log.size(), res_log.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        per[iss_log[k].idx]++;
        checks++;
        if (iss_log[k].idx != k % N || iss_log[k].cyc != iss_log[0].cyc + k) begin
          errors++;
          $display("FAIL fair_order[%0d]: grant %0d at +%0d required %0d at +%0d",
                   k, iss_log[k].idx, iss_log[k].cyc - iss_log[0].cyc, k % N, k);
        end
        checks++;
        if (res_log[k].idx != iss_log[k].idx || res_log[k].data !== iss_log[k].data) begin
          errors++;
          $display("FAIL fair_result[%0d]: owner %0d data %h required owner %0d data %h",
                   k, res_log[k].idx, res_log[k].data, iss_log[k].idx, iss_log[k].data);
        end
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (per[i] != 4) begin
          errors++;
          $display("FAIL fair_per_req[%0d]: granted %0d required 4", i, per[i]);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_back_pressure();
    int stalls;
    bit early0, found;
    stalls = 0; early0 = 0; found = 0;
    m_ready = 4'b1011;
    n_left[2] = 1; new_req(2);
    step();
    n_left[0] = 1; new_req(0);
    for (int t = 0; t < 80 && !found; t++) begin
      step();
      if (smp_mvalid[2]) found = 1;
    end
    if (found && !smp_rready) stalls++;
    repeat (9) begin
      step();
      if (!smp_rready) stalls++;
      if (smp_mvalid[0]) early0 = 1;
    end
    m_ready = '1;
    for (int t = 0; t < 30 && res_log.size() < 2; t++) step();
    checks++;
    if (stalls != 10 || early0) begin
      errors++;
      $display("FAIL bp_stall: dot_result_tready low %0d cycles (req0 early=%0d) required 10 (0)", stalls, early0);
    end
    checks++;
    if (res_log.size() != 2 || iss_log.size() != 2) begin
      errors++;
      $display("FAIL bp_count: results=%0d required 2", res_log.size());
    end else begin
      checks++;
      if (res_log[0].idx != 2 || res_log[1].idx != 0 || res_log[0].data !== iss_log[0].data ||
          res_log[1].data !== iss_log[1].data) begin
        errors++;
        $display("FAIL bp_order: owners %0d,%0d data %h,%h required 2,0 data %h,%h", res_log[0].idx,
                 res_log[1].idx, res_log[0].data, res_log[1].data, iss_log[0].data, iss_log[1].data);
      end
      checks++;
      if (res_log[0].cyc - iss_log[0].cyc != LAT + 10 || res_log[1].cyc != res_log[0].cyc + 1) begin
        errors++;
        $display("FAIL bp_timing: req2 latency %0d req0 gap %0d required %0d and 1",
                 res_log[0].cyc - iss_log[0].cyc, res_log[1].cyc - res_log[0].cyc, LAT + 10);
      end
    end
    do_reset();
  endtask

  task automatic test_credit();
    hold = 1;
    for (int i = 0; i < N; i++) begin n_left[i] = 1000; new_req(i); end
    repeat (60) step();
    checks++;
    if (iss_log.size() != MO || smp_ready !== '0 || outst != MO) begin
      errors++;
      $display("FAIL credit_limit: issues=%0d tready=%b required %0d and 0000", iss_log.size(), smp_ready, MO);
    end
    hold = 0;
    step();
    hold = 1;
    step();
    repeat (10) step();
    checks++;
    if (iss_log.size() != MO + 1 || smp_ready !== '0 || outst != MO) begin
      errors++;
      $display("FAIL credit_one_retire: issues=%0d in flight=%0d required %0d and %0d",
               iss_log.size(), outst, MO + 1, MO);
    end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0; hold = 0;
    clear_logs();
    for (int i = 0; i < N; i++) n_left[i] = 1;
    step();
    checks++;
    if (smp_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_midflight_grant: tready=%b required 0001", smp_ready);
    end
    for (int t = 0; t < 100 && res_log.size() < N; t++) step();
    checks++;
    if (res_log.size() != N || err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL reset_midflight_drain: results=%0d err=%b required %0d and 0", res_log.size(), err_orphan, N);
    end else begin
      for (int k = 0; k < N; k++) begin
        checks++;
        if (res_log[k].idx != k || res_log[k].data !== iss_log[k].data) begin
          errors++;
          $display("FAIL reset_midflight_result[%0d]: owner %0d data %h required %0d data %h",
                   k, res_log[k].idx, res_log[k].data, k, iss_log[k].data);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_orphan();
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_initial: err=%b required 0", err_orphan);
    end
    inj = 1;
    drive_model();
    step();
    inj = 0;
    drive_model();
    checks++;
    if (smp_rready !== 1'b1 || smp_mvalid !== '0) begin
      errors++;
      $display("FAIL orphan_drop: dot_result_tready=%b mvalid=%b required 1 and 0000", smp_rready, smp_mvalid);
    end
    repeat (5) step();
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_sticky: err=%b required 1", err_orphan);
    end
    do_reset();
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_clear: err=%b required 0", err_orphan);
    end
  endtask

  task automatic test_random();
    int p, g, k2;
    logic [N-1:0] exp_rdy;
    auto_rand = 1;
    repeat (500) begin
      dot_tready = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < N; i++) m_ready[i] = ($urandom_range(0, 3) != 0);
      step();
    end
    auto_rand = 0; dot_tready = 1'b1; m_ready = '1;
    for (int t = 0; t < 400 && (outst != 0 || s_valid != '0); t++) step();
    repeat (3) step();
    p = 0;
    foreach (cyc_log[c]) begin
      exp_rdy = '0;
      g = -1;
      if (cyc_log[c].mask != '0 && cyc_log[c].dtr && cyc_log[c].outst < MO)
        for (int k = N - 1; k >= 0; k--) begin
          k2 = (p + k) % N;
          if (cyc_log[c].mask[k2]) g = k2;
        end
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        p = (g + 1) % N;
      end
      checks++;
      if (cyc_log[c].rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rand_grant[%0d]: tready=%b required %b (valid=%b in flight=%0d)",
                 c, cyc_log[c].rdy, exp_rdy, cyc_log[c].mask, cyc_log[c].outst);
      end
    end
    checks++;
    if (res_log.size() != iss_log.size() || outst != 0 || err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: results=%0d issues=%0d in flight=%0d err=%b required equal, 0, 0",
               res_log.size(), iss_log.size(), outst, err_orphan);
    end else begin
      foreach (res_log[k]) begin
        checks++;
        if (res_log[k].idx != iss_log[k].idx || res_log[k].data !== iss_log[k].data) begin
          errors++;
          $display("FAIL rand_result[%0d]: owner %0d data %h required owner %0d data %h",
                   k, res_log[k].idx, res_log[k].data, iss_log[k].idx, iss_log[k].data);
        end
      end
    end
    do_reset();
  endtask

  initial begin
    a_d = '0; b_d = '0; s_valid = '0; m_ready = '1; dot_tready = 1'b1;
    hold = 0; inj = 0; auto_rand = 0;
    for (int i = 0; i < N; i++) n_left[i] = 0;
    drive_model();
    @(negedge aclk);
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_credit();
    test_orphan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
